btle_phy_cfg_regfile: RTL and testbench

BTLE_PHY_CFG_REGFILE -- requirements
Module: btle_phy_cfg_regfile

---
 rtl/btle_phy_cfg_regfile.sv | 266 ++++++++++++++++++++++++++
 tb/tb_btle_phy_cfg_regfile.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/btle_phy_cfg_regfile.sv
// Host-facing configuration register file for the BTLE PHY, driven by UART-framed commands.
// Define BTLE_PHY_CFG_READBACK_EN to enable the 0x52 register read command.
module btle_phy_cfg_regfile #(
  parameter int CRC_STATE_BIT_WIDTH      = 24,
  parameter int CHANNEL_NUMBER_BIT_WIDTH = 6,
  parameter int GAUSS_FILTER_BIT_WIDTH   = 16,
  parameter int SIN_COS_ADDR_BIT_WIDTH   = 11,
  parameter int IQ_BIT_WIDTH             = 8,
  parameter int LEN_UNIQUE_BIT_SEQUENCE  = 32,
  parameter int TIMEOUT_CYCLES           = 16000
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [7:0]                          cmd_byte,
  input  logic                                cmd_valid,
  output logic [7:0]                          resp_byte,
  output logic                                resp_valid,
  input  logic                                resp_ready,
  output logic [3:0]                          tx_gauss_tap_index,
  output logic [GAUSS_FILTER_BIT_WIDTH-1:0]   tx_gauss_tap_value,
  output logic                                tx_gauss_tap_we,
  output logic [SIN_COS_ADDR_BIT_WIDTH-1:0]   tx_cos_addr,
  output logic [IQ_BIT_WIDTH-1:0]             tx_cos_data,
  output logic                                tx_cos_we,
  output logic [SIN_COS_ADDR_BIT_WIDTH-1:0]   tx_sin_addr,
  output logic [IQ_BIT_WIDTH-1:0]             tx_sin_data,
  output logic                                tx_sin_we,
  output logic [7:0]                          tx_preamble,
  output logic [31:0]                         tx_access_address,
  output logic [CRC_STATE_BIT_WIDTH-1:0]      tx_crc_init,
  output logic                                tx_crc_init_load,
  output logic [CHANNEL_NUMBER_BIT_WIDTH-1:0] tx_channel,
  output logic                                tx_channel_load,
  output logic [5:0]                          tx_pdu_addr,
  output logic [7:0]                          tx_pdu_data,
  output logic                                tx_pdu_we,
  output logic                                tx_start,
  output logic [LEN_UNIQUE_BIT_SEQUENCE-1:0]  rx_unique_bit_sequence,
  output logic [CHANNEL_NUMBER_BIT_WIDTH-1:0] rx_channel,
  output logic [CRC_STATE_BIT_WIDTH-1:0]      rx_crc_init,
  input  logic                                rx_hit_flag,
  input  logic                                rx_decode_run,
  input  logic                                rx_decode_end,
  input  logic                                rx_crc_ok,
  input  logic [2:0]                          rx_best_phase,
  input  logic [6:0]                          rx_payload_length,
  output logic [5:0]                          rx_pdu_addr,
  input  logic [7:0]                          rx_pdu_data
);

`ifdef BTLE_PHY_CFG_READBACK_EN
  localparam bit READBACK = 1'b1;
`else
  localparam bit READBACK = 1'b0;
`endif

  localparam logic [7:0] OP_WR = 8'h57, OP_RD = 8'h52, RSP_ACK = 8'h4B, RSP_ERR = 8'hEE;
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_EXEC, S_RESP} state_t;

  state_t state_q, state_d;
  logic op_rd_q, op_rd_d;
  logic [7:0] addr_q, addr_d;
  logic [23:0] frame_q, frame_d;
  logic [1:0] cnt_q, cnt_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic resp_valid_q, resp_valid_d;
  logic [7:0] resp_byte_q, resp_byte_d;
  logic [23:0] resp_sr_q, resp_sr_d;
  logic [1:0] resp_left_q, resp_left_d;
  logic done_q, done_d, ovf_q, ovf_d;

  logic [3:0] tap_index_q, tap_index_d;
  logic [GAUSS_FILTER_BIT_WIDTH-1:0] tap_value_q, tap_value_d;
  logic [SIN_COS_ADDR_BIT_WIDTH-1:0] cos_addr_q, cos_addr_d, sin_addr_q, sin_addr_d;
  logic [IQ_BIT_WIDTH-1:0] cos_data_q, cos_data_d, sin_data_q, sin_data_d;
  logic [7:0] preamble_q, preamble_d;
  logic [31:0] aa_q, aa_d;
  logic [CRC_STATE_BIT_WIDTH-1:0] tx_crc_q, tx_crc_d, rx_crc_q, rx_crc_d;
  logic [CHANNEL_NUMBER_BIT_WIDTH-1:0] tx_ch_q, tx_ch_d, rx_ch_q, rx_ch_d;
  logic [5:0] pdu_addr_q, pdu_addr_d, rx_pdu_addr_q, rx_pdu_addr_d;
  logic [7:0] pdu_data_q, pdu_data_d;
  logic [LEN_UNIQUE_BIT_SEQUENCE-1:0] useq_q, useq_d;
  logic [6:0] stb_q, stb_d;  // {start, pdu, ch, crc, sin, cos, tap}

  logic [31:0] wdata, rd_val;
  logic rd_ok, wr_ok, drop, clr_status;

  always_comb begin
    state_d = state_q;  op_rd_d = op_rd_q;  addr_d = addr_q;  frame_d = frame_q;
    cnt_d = cnt_q;  tmr_d = tmr_q;
    resp_valid_d = resp_valid_q;  resp_byte_d = resp_byte_q;
    resp_sr_d = resp_sr_q;  resp_left_d = resp_left_q;
    tap_index_d = tap_index_q;  tap_value_d = tap_value_q;
    cos_addr_d = cos_addr_q;  cos_data_d = cos_data_q;
    sin_addr_d = sin_addr_q;  sin_data_d = sin_data_q;
    preamble_d = preamble_q;  aa_d = aa_q;  tx_crc_d = tx_crc_q;  tx_ch_d = tx_ch_q;
    pdu_addr_d = pdu_addr_q;  pdu_data_d = pdu_data_q;
    useq_d = useq_q;  rx_ch_d = rx_ch_q;  rx_crc_d = rx_crc_q;  rx_pdu_addr_d = rx_pdu_addr_q;
    stb_d = '0;
    drop = 1'b0;
    clr_status = 1'b0;
    wdata = {cmd_byte, frame_q};
    wr_ok = (addr_q <= 8'h0D) && (addr_q != 8'h0C);

    rd_ok = 1'b1;
    rd_val = '0;
    case (addr_q)
      8'h00: begin rd_val[3:0] = tap_index_q; rd_val[16 +: GAUSS_FILTER_BIT_WIDTH] = tap_value_q; end
      8'h01: begin rd_val[SIN_COS_ADDR_BIT_WIDTH-1:0] = cos_addr_q; rd_val[16 +: IQ_BIT_WIDTH] = cos_data_q; end
      8'h02: begin rd_val[SIN_COS_ADDR_BIT_WIDTH-1:0] = sin_addr_q; rd_val[16 +: IQ_BIT_WIDTH] = sin_data_q; end
      8'h03: rd_val[7:0] = preamble_q;
      8'h04: rd_val = aa_q;
      8'h05: rd_val[CRC_STATE_BIT_WIDTH-1:0] = tx_crc_q;
      8'h06: rd_val[CHANNEL_NUMBER_BIT_WIDTH-1:0] = tx_ch_q;
      8'h07: begin rd_val[5:0] = pdu_addr_q; rd_val[15:8] = pdu_data_q; end
      8'h08: rd_val = '0;
      8'h09: rd_val[LEN_UNIQUE_BIT_SEQUENCE-1:0] = useq_q;
      8'h0A: rd_val[CHANNEL_NUMBER_BIT_WIDTH-1:0] = rx_ch_q;
      8'h0B: rd_val[CRC_STATE_BIT_WIDTH-1:0] = rx_crc_q;
      // done/overflow sit at bits 11/12; run and hit occupy the next two bits up
      8'h0C: rd_val[14:0] = {rx_hit_flag, rx_decode_run, ovf_q, done_q, rx_crc_ok,
                             rx_best_phase, rx_payload_length};
      8'h0D: rd_val[7:0] = rx_pdu_data;
      default: rd_ok = 1'b0;
    endcase

    if (resp_valid_q && resp_ready) begin
      if (resp_left_q == 2'd0) begin
        resp_valid_d = 1'b0;
      end else begin
        resp_byte_d = resp_sr_q[7:0];
        resp_sr_d   = {8'h00, resp_sr_q[23:8]};
        resp_left_d = resp_left_q - 2'd1;
      end
    end

    case (state_q)
      S_IDLE: if (cmd_valid) begin
        // an error byte still waiting on the transmitter makes the block busy
        if (resp_valid_q) begin
          drop = 1'b1;
        end else if (cmd_byte == OP_WR || (READBACK && cmd_byte == OP_RD)) begin
          op_rd_d = (cmd_byte == OP_RD);
          tmr_d   = TMR_LOAD;
          state_d = S_ADDR;
        end else begin
          resp_valid_d = 1'b1;
          resp_byte_d  = RSP_ERR;
          resp_left_d  = 2'd0;
        end
      end
      S_ADDR: if (cmd_valid) begin
        addr_d = cmd_byte;
        cnt_d  = 2'd0;
        tmr_d  = TMR_LOAD;
        state_d = op_rd_q ? S_EXEC : S_DATA;
      end else if (tmr_q == '0) begin
        state_d = S_IDLE;
      end else begin
        tmr_d = tmr_q - 1'b1;
      end
      S_DATA: if (cmd_valid) begin
        tmr_d = TMR_LOAD;
        cnt_d = cnt_q + 2'd1;
        case (cnt_q)
          2'd0: frame_d[7:0]   = cmd_byte;
          2'd1: frame_d[15:8]  = cmd_byte;
          2'd2: frame_d[23:16] = cmd_byte;
          default: begin
            state_d = S_EXEC;
            case (addr_q)
              8'h00: begin tap_index_d = wdata[3:0]; tap_value_d = wdata[16 +: GAUSS_FILTER_BIT_WIDTH]; stb_d[0] = 1'b1; end
              8'h01: begin cos_addr_d = wdata[SIN_COS_ADDR_BIT_WIDTH-1:0]; cos_data_d = wdata[16 +: IQ_BIT_WIDTH]; stb_d[1] = 1'b1; end
              8'h02: begin sin_addr_d = wdata[SIN_COS_ADDR_BIT_WIDTH-1:0]; sin_data_d = wdata[16 +: IQ_BIT_WIDTH]; stb_d[2] = 1'b1; end
              8'h03: preamble_d = wdata[7:0];
              8'h04: aa_d = wdata;
              8'h05: begin tx_crc_d = wdata[CRC_STATE_BIT_WIDTH-1:0]; stb_d[3] = 1'b1; end
              8'h06: begin tx_ch_d = wdata[CHANNEL_NUMBER_BIT_WIDTH-1:0]; stb_d[4] = 1'b1; end
              8'h07: begin pdu_addr_d = wdata[5:0]; pdu_data_d = wdata[15:8]; stb_d[5] = 1'b1; end
              8'h08: stb_d[6] = 1'b1;
              8'h09: useq_d = wdata[LEN_UNIQUE_BIT_SEQUENCE-1:0];
              8'h0A: rx_ch_d = wdata[CHANNEL_NUMBER_BIT_WIDTH-1:0];
              8'h0B: rx_crc_d = wdata[CRC_STATE_BIT_WIDTH-1:0];
              8'h0D: rx_pdu_addr_d = wdata[5:0];
              default: ;
            endcase
          end
        endcase
      end else if (tmr_q == '0) begin
        state_d = S_IDLE;
      end else begin
        tmr_d = tmr_q - 1'b1;
      end
      S_EXEC: begin
        drop = cmd_valid;
        resp_valid_d = 1'b1;
        state_d = S_RESP;
        if (op_rd_q && rd_ok) begin
          resp_byte_d = rd_val[7:0];
          resp_sr_d   = rd_val[31:8];
          resp_left_d = 2'd3;
          clr_status  = (addr_q == 8'h0C);
        end else begin
          resp_byte_d = (!op_rd_q && wr_ok) ? RSP_ACK : RSP_ERR;
          resp_left_d = 2'd0;
        end
      end
      S_RESP: begin
        drop = cmd_valid;
        if (resp_valid_q && resp_ready && resp_left_q == 2'd0) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    done_d = (done_q & ~clr_status) | rx_decode_end;
    ovf_d  = (ovf_q & ~clr_status) | drop;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;  op_rd_q <= 1'b0;  addr_q <= '0;  frame_q <= '0;  cnt_q <= '0;  tmr_q <= '0;
      resp_valid_q <= 1'b0;  resp_byte_q <= '0;  resp_sr_q <= '0;  resp_left_q <= '0;
      done_q <= 1'b0;  ovf_q <= 1'b0;  stb_q <= '0;
      tap_index_q <= '0;  tap_value_q <= '0;  cos_addr_q <= '0;  cos_data_q <= '0;
      sin_addr_q <= '0;  sin_data_q <= '0;  preamble_q <= '0;  aa_q <= '0;
      tx_crc_q <= '0;  tx_ch_q <= '0;  pdu_addr_q <= '0;  pdu_data_q <= '0;
      useq_q <= '0;  rx_ch_q <= '0;  rx_crc_q <= '0;  rx_pdu_addr_q <= '0;
    end else begin
      state_q <= state_d;  op_rd_q <= op_rd_d;  addr_q <= addr_d;  frame_q <= frame_d;
      cnt_q <= cnt_d;  tmr_q <= tmr_d;
      resp_valid_q <= resp_valid_d;  resp_byte_q <= resp_byte_d;
      resp_sr_q <= resp_sr_d;  resp_left_q <= resp_left_d;
      done_q <= done_d;  ovf_q <= ovf_d;  stb_q <= stb_d;
      tap_index_q <= tap_index_d;  tap_value_q <= tap_value_d;
      cos_addr_q <= cos_addr_d;  cos_data_q <= cos_data_d;
      sin_addr_q <= sin_addr_d;  sin_data_q <= sin_data_d;
      preamble_q <= preamble_d;  aa_q <= aa_d;  tx_crc_q <= tx_crc_d;  tx_ch_q <= tx_ch_d;
      pdu_addr_q <= pdu_addr_d;  pdu_data_q <= pdu_data_d;
      useq_q <= useq_d;  rx_ch_q <= rx_ch_d;  rx_crc_q <= rx_crc_d;  rx_pdu_addr_q <= rx_pdu_addr_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_byte  = resp_byte_q;
  assign {tx_start, tx_pdu_we, tx_channel_load, tx_crc_init_load, tx_sin_we, tx_cos_we, tx_gauss_tap_we} = stb_q;
  assign tx_gauss_tap_index = tap_index_q;
  assign tx_gauss_tap_value = tap_value_q;
  assign tx_cos_addr = cos_addr_q;
  assign tx_cos_data = cos_data_q;
  assign tx_sin_addr = sin_addr_q;
  assign tx_sin_data = sin_data_q;
  assign tx_preamble = preamble_q;
  assign tx_access_address = aa_q;
  assign tx_crc_init = tx_crc_q;
  assign tx_channel  = tx_ch_q;
  assign tx_pdu_addr = pdu_addr_q;
  assign tx_pdu_data = pdu_data_q;
  assign rx_unique_bit_sequence = useq_q;
  assign rx_channel  = rx_ch_q;
  assign rx_crc_init = rx_crc_q;
  assign rx_pdu_addr = rx_pdu_addr_q;

endmodule

// File: tb/tb_btle_phy_cfg_regfile.sv
// Scoreboard bench for btle_phy_cfg_regfile: expected responses and strobes are queued at
// stimulus time and consumed by an independent monitor; register state kept as a masked array.
module tb_btle_phy_cfg_regfile;
  localparam int TMO = 16000;
`ifdef BTLE_PHY_CFG_READBACK_EN
  localparam bit READBACK = 1'b1;
`else
  localparam bit READBACK = 1'b0;
`endif

  logic clk = 1'b0, rst = 1'b1;
  logic [7:0] cmd_byte = '0, resp_byte;
  logic cmd_valid = 1'b0, resp_valid, resp_ready = 1'b1;
  logic [3:0] tap_index;  logic [15:0] tap_value;  logic tap_we;
  logic [10:0] cos_addr, sin_addr;  logic [7:0] cos_data, sin_data;  logic cos_we, sin_we;
  logic [7:0] preamble;  logic [31:0] aa;
  logic [23:0] tx_crc, rx_crc;  logic crc_load;
  logic [5:0] tx_ch, rx_ch;  logic ch_load;
  logic [5:0] pdu_addr;  logic [7:0] pdu_data;  logic pdu_we, tx_start;
  logic [31:0] useq;
  logic hit = 0, run = 0, dec_end = 0, crc_ok = 0;
  logic [2:0] phase = '0;  logic [6:0] plen = '0;
  logic [5:0] rx_pdu_addr;  logic [7:0] rx_pdu_data = '0;

  btle_phy_cfg_regfile #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .cmd_byte(cmd_byte), .cmd_valid(cmd_valid),
    .resp_byte(resp_byte), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .tx_gauss_tap_index(tap_index), .tx_gauss_tap_value(tap_value), .tx_gauss_tap_we(tap_we),
    .tx_cos_addr(cos_addr), .tx_cos_data(cos_data), .tx_cos_we(cos_we),
    .tx_sin_addr(sin_addr), .tx_sin_data(sin_data), .tx_sin_we(sin_we),
    .tx_preamble(preamble), .tx_access_address(aa),
    .tx_crc_init(tx_crc), .tx_crc_init_load(crc_load),
    .tx_channel(tx_ch), .tx_channel_load(ch_load),
    .tx_pdu_addr(pdu_addr), .tx_pdu_data(pdu_data), .tx_pdu_we(pdu_we), .tx_start(tx_start),
    .rx_unique_bit_sequence(useq), .rx_channel(rx_ch), .rx_crc_init(rx_crc),
    .rx_hit_flag(hit), .rx_decode_run(run), .rx_decode_end(dec_end), .rx_crc_ok(crc_ok),
    .rx_best_phase(phase), .rx_payload_length(plen),
    .rx_pdu_addr(rx_pdu_addr), .rx_pdu_data(rx_pdu_data)
  );

  always #5 clk = ~clk;

  typedef struct { int id; logic [31:0] val; } sev_t;
  int n_tests = 0, n_fail = 0;
  logic [7:0] exp_q[$];
  sev_t sq[$];
  logic [31:0] mdl_reg [0:13];
  logic mdl_done = 1'b0, mdl_ovf = 1'b0;
  logic [7:0] ram [0:63];
  bit rand_ready = 1'b0;

  always @(posedge clk) rx_pdu_data <= ram[rx_pdu_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] reg_mask(input int a);
    case (a)
      0:       return 32'hFFFF_000F;
      1, 2:    return 32'h00FF_07FF;
      3:       return 32'h0000_00FF;
      4, 9:    return 32'hFFFF_FFFF;
      5, 11:   return 32'h00FF_FFFF;
      6, 10:   return 32'h0000_003F;
      7:       return 32'h0000_FF3F;
      13:      return 32'h0000_003F;
      default: return 32'h0;
    endcase
  endfunction

  // status word as seen by a read: bit12 overflow, bit11 done, bit10 crc_ok, [9:7] phase, [6:0] length
  function automatic logic [31:0] status_word();
    return (32'(mdl_ovf) << 12) | (32'(mdl_done) << 11) | (32'(crc_ok) << 10) |
           (32'(phase) << 7) | 32'(plen);
  endfunction

  task automatic model_frame(input logic [7:0] op, input int a, input logic [31:0] d);
    logic [31:0] v;
    if (op == 8'h57) begin
      if (a <= 13 && a != 12) begin
        mdl_reg[a] = d & reg_mask(a);
        exp_q.push_back(8'h4B);
        if (a inside {0, 1, 2, 5, 6, 7, 8}) sq.push_back('{a, d & reg_mask(a)});
      end else exp_q.push_back(8'hEE);
    end else if (op == 8'h52 && READBACK) begin
      if (a <= 13) begin
        if (a == 12) begin v = status_word(); mdl_done = 1'b0; mdl_ovf = 1'b0; end
        else if (a == 13) v = {24'h0, ram[mdl_reg[13][5:0]]};
        else v = mdl_reg[a];
        for (int i = 0; i < 4; i++) exp_q.push_back(v[8*i +: 8]);
      end else exp_q.push_back(8'hEE);
    end else exp_q.push_back(8'hEE);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    cmd_byte = b;  cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    repeat ($urandom_range(0, 3)) tick();
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || sq.size() != 0) && n < 300) begin tick(); n++; end
    n_tests++;
    if (n >= 300) begin
      n_fail++;
      $display("FAIL wait_idle: %0d responses and %0d strobes outstanding, expected 0", exp_q.size(), sq.size());
    end
    repeat (3) tick();
  endtask

  task automatic send_frame(input logic [7:0] op, input int a, input logic [31:0] d);
    model_frame(op, a, d);
    send_byte(op);
    if (op == 8'h57 || (op == 8'h52 && READBACK)) begin
      send_byte(8'(a));
      if (op == 8'h57) for (int i = 0; i < 4; i++) send_byte(d[8*i +: 8]);
    end
    wait_idle();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_strobes"}, {25'h0, tap_we, cos_we, sin_we, crc_load, ch_load, pdu_we, tx_start}, 32'h0);
    chk({tag, "_resp"}, {23'h0, resp_valid, resp_byte}, 32'h0);
    chk({tag, "_aa"}, aa, 32'h0);
    chk({tag, "_tx"}, {preamble, tx_ch, pdu_addr, pdu_data, tap_index}, 32'h0);
    chk({tag, "_tables"}, {tap_value, cos_data, sin_data} | {cos_addr, sin_addr}, 32'h0);
    chk({tag, "_crc"}, {tx_crc, 8'h0} | {8'h0, rx_crc}, 32'h0);
    chk({tag, "_rx"}, useq | {20'h0, rx_ch, rx_pdu_addr}, 32'h0);
  endtask

  always @(negedge clk) begin : mon
    int id, hits;
    logic [31:0] act;
    sev_t e;
    if (!rst) begin
      if (resp_valid && resp_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL resp_unexpected: got %h expected no response", resp_byte);
        end else chk("resp_byte", resp_byte, exp_q.pop_front());
      end
      hits = int'(tap_we) + int'(cos_we) + int'(sin_we) + int'(crc_load) + int'(ch_load) +
             int'(pdu_we) + int'(tx_start);
      if (hits != 0) begin
        if (tap_we)        begin id = 0; act = {tap_value, 12'h0, tap_index}; end
        else if (cos_we)   begin id = 1; act = {8'h0, cos_data, 5'h0, cos_addr}; end
        else if (sin_we)   begin id = 2; act = {8'h0, sin_data, 5'h0, sin_addr}; end
        else if (crc_load) begin id = 5; act = {8'h0, tx_crc}; end
        else if (ch_load)  begin id = 6; act = {26'h0, tx_ch}; end
        else if (pdu_we)   begin id = 7; act = {16'h0, pdu_data, 2'b0, pdu_addr}; end
        else               begin id = 8; act = 32'h0; end
        chk("strobe_count", hits, 1);
        if (sq.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL strobe_unexpected: got strobe %0d expected none", id);
        end else begin
          e = sq.pop_front();
          chk("strobe_id", id, e.id);
          chk("strobe_val", act, e.val);
        end
      end
    end
  end

  initial begin
    forever begin
      tick();
      if (rand_ready) resp_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] op;
    int a, kind;
    logic [31:0] d;
    for (int i = 0; i < 64; i++) ram[i] = 8'($urandom);
    for (int i = 0; i < 14; i++) mdl_reg[i] = '0;
    repeat (3) tick();
    chk_all_zero("reset");
    rst = 1'b0;

    send_frame(8'h57, 6, 32'h0000_0025);
    chk("tx_channel", {26'h0, tx_ch}, 32'h25);
    send_frame(8'h57, 1, 32'h007F_07FF);
    chk("tx_cos", {cos_data, 5'h0, cos_addr}, {8'h7F, 5'h0, 11'h7FF});

    plen = 7'd37;
    dec_end = 1'b1; tick(); dec_end = 1'b0;
    mdl_done = 1'b1;
    send_frame(8'h52, 12, 32'h0);
    send_frame(8'h52, 12, 32'h0);

    // backpressure while a byte is injected mid-response
    resp_ready = 1'b0;
    model_frame(8'h57, 3, 32'h0000_00AB);
    send_byte(8'h57); send_byte(8'h03); send_byte(8'hAB);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    repeat (3) tick();
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", {31'h0, resp_valid}, 32'h1);
      chk("bp_byte", resp_byte, 8'h4B);
      if (i == 4) begin cmd_byte = 8'h57; cmd_valid = 1'b1; tick(); cmd_valid = 1'b0; end
      else tick();
    end
    mdl_ovf = 1'b1;
    resp_ready = 1'b1;
    wait_idle();
    send_frame(8'h52, 12, 32'h0);
    send_frame(8'h57, 10, 32'h0000_0011);
    chk("rx_channel", {26'h0, rx_ch}, 32'h11);

    // aborted frame after the timeout, then a frame kept alive just under it
    send_byte(8'h57); send_byte(8'h04);
    repeat (TMO + 5) tick();
    chk("tmo_aa", aa, mdl_reg[4]);
    send_frame(8'h33, 0, 32'h0);
    model_frame(8'h57, 4, 32'hCAFE_F00D);
    cmd_byte = 8'h57; cmd_valid = 1'b1; tick(); cmd_valid = 1'b0;
    cmd_byte = 8'h04; cmd_valid = 1'b1; tick(); cmd_valid = 1'b0;
    repeat (TMO - 3) tick();
    send_byte(8'h0D); send_byte(8'hF0); send_byte(8'hFE); send_byte(8'hCA);
    wait_idle();
    chk("keepalive_aa", aa, 32'hCAFE_F00D);

    send_byte(8'h57); send_byte(8'h05); send_byte(8'h11); send_byte(8'h22);
    rst = 1'b1;
    tick(); tick();
    chk_all_zero("midreset");
    for (int i = 0; i < 14; i++) mdl_reg[i] = '0;
    mdl_done = 1'b0; mdl_ovf = 1'b0;
    exp_q.delete(); sq.delete();
    rst = 1'b0;
    send_frame(8'h57, 5, 32'h00AB_CDEF);
    chk("post_reset_crc", {8'h0, tx_crc}, 32'h00AB_CDEF);

    rand_ready = 1'b1;
    crc_ok = 1'b1; phase = 3'd5;
    for (int k = 0; k < 40; k++) begin
      kind = $urandom_range(0, 9);
      a = $urandom_range(0, 15);
      d = $urandom;
      if (kind < 6) op = 8'h57;
      else if (kind < 9) op = 8'h52;
      else begin
        op = 8'($urandom_range(0, 255));
        if (op == 8'h57 || op == 8'h52) op = 8'h33;
      end
      send_frame(op, a, d);
    end
    rand_ready = 1'b0;
    resp_ready = 1'b1;
    repeat (3) tick();

    chk("end_tap", {tap_value, 12'h0, tap_index}, mdl_reg[0]);
    chk("end_cos", {8'h0, cos_data, 5'h0, cos_addr}, mdl_reg[1]);
    chk("end_sin", {8'h0, sin_data, 5'h0, sin_addr}, mdl_reg[2]);
    chk("end_preamble", {24'h0, preamble}, mdl_reg[3]);
    chk("end_aa", aa, mdl_reg[4]);
    chk("end_tx_crc", {8'h0, tx_crc}, mdl_reg[5]);
    chk("end_tx_ch", {26'h0, tx_ch}, mdl_reg[6]);
    chk("end_pdu", {16'h0, pdu_data, 2'b0, pdu_addr}, mdl_reg[7]);
    chk("end_useq", useq, mdl_reg[9]);
    chk("end_rx_ch", {26'h0, rx_ch}, mdl_reg[10]);
    chk("end_rx_crc", {8'h0, rx_crc}, mdl_reg[11]);
    chk("end_rx_pdu_addr", {26'h0, rx_pdu_addr}, mdl_reg[13]);
    chk("end_queues", exp_q.size() + sq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
